lsb_two_approx_rc_adder: RTL and testbench
==========================================

# lsb_two_approx_rc_adder

Registered 8-bit ripple-carry adder with the two least-significant bit positions built from approximate full-adder cells. Bits [7:2] use exact full adders. It sits in the image-filter datapath (Laplace filter accumulation), where small LSB errors are accepted in exchange for a shorter, cheaper carry chain. Results are captured in an output register one clock after the operands are presented.

## Interface
- WIDTH, 8: operand and sum width; must be at least APPROX_BITS + 1.
- APPROX_BITS, 2: number of LSB positions using the approximate cell; bits [WIDTH-1:APPROX_BITS] are exact.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry into bit 0.
- S  output  WIDTH  registered approximate sum.
- Cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- Ripple chain: c[0] = Cin; bit i takes A[i], B[i], c[i] and produces s[i] and c[i+1]; Cout = c[WIDTH].
- Approximate cell, used for i < APPROX_BITS:
  - carry: c[i+1] = majority(A[i], B[i], c[i]). This carry is exact.
  - sum: s[i] = NOT c[i+1].
  - The sum bit is wrong only when A[i]=B[i]=c[i]. Inputs 000 give s=1. Inputs 111 give s=0.
- Exact cell, used for i >= APPROX_BITS: s[i] = A[i] xor B[i] xor c[i]; c[i+1] = majority.
- Consequences:
  - Every carry in the chain equals the exact carry, so the upper bits and Cout are always exact.
  - The error is confined to S[APPROX_BITS-1:0].
  - Result {Cout,S} is unsigned 9 bits for WIDTH=8, range 0..511.
- Combinational result {c[WIDTH], s} is captured into the {Cout,S} register on every rising clk edge. There is no enable and no handshake.

## Timing
- Latency: 1 cycle. Operands stable before rising edge k appear on S/Cout after edge k.
- Throughput: one new operand set per cycle.
- Reset:
  - While rst=1, S = 0 and Cout = 0, asynchronously, independent of clk.
  - Asserting rst mid-stream discards the pending result.
  - The first edge after rst deasserts captures the operands present at that edge.
- Operand changes between edges have no effect on outputs. Outputs are glitch-free (register-driven).
- The combinational path is the full WIDTH-bit ripple. It must close at the target clock, 100 MHz nominal.

## Test plan
- Reset: drive A=0xFF, B=0xFF, Cin=1, assert rst between edges -> S=0x00, Cout=0 immediately. They stay 0 through edges while rst=1. After release, the next edge gives {Cout,S}=0x1FC (exact sum 0x1FF; bits 1:0 read 00).
- All-zero error case: A=0, B=0, Cin=0 -> after one edge {Cout,S}=3 (S=0x03, Cout=0). This shows the 000 sum error in both approximate bits.
- Error-free and carry cases:
  - A=0xAA, B=0x55, Cin=0 -> {Cout,S}=255, exact.
  - A=0xFF, B=0x01, Cin=0 -> {Cout,S}=256 (S=0x00, Cout=1). The carry propagates through the approximate cells exactly.
- Mixed error: A=200, B=100, Cin=0 -> {Cout,S}=303 (S=0x2F, Cout=1; exact 300). A=3, B=3, Cin=1 -> S=0x04, Cout=0 (exact 7).
- Exhaustive: sweep A=0..255 and B=0..255 with Cin=0, one pair per cycle. Compare {Cout,S} against a cell-level reference model. Check that S[7:2] and Cout always equal the exact sum bits. Check |approx - exact| <= 3 for every pair.
- Back-to-back: change operands every cycle (e.g. 0+0, then 255+1, then 170+85) -> outputs 3, 256, 255 on consecutive edges, each one cycle after its operands, with no stale or merged results.

Source files
------------

// File: rtl/lsb_two_approx_rc_adder.sv
// Registered ripple-carry adder whose low APPROX_BITS positions use approximate
// full-adder cells. The sum there is derived from the carry, and the carry itself stays exact.
module lsb_two_approx_rc_adder #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    if (i < APPROX_BITS) begin : g_approx
      // Inverted carry matches the true sum except when all three inputs are equal.
      assign s_comb[i] = ~c[i+1];
    end else begin : g_exact
      assign s_comb[i] = A[i] ^ B[i] ^ c[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= s_comb;
      Cout <= c[WIDTH];
    end
  end

endmodule

// File: tb/tb_lsb_two_approx_rc_adder.sv
// Directed and exhaustive bench for lsb_two_approx_rc_adder; expected results
// travel through a scoreboard queue from the drive point to the capture point.
module tb_lsb_two_approx_rc_adder;

  typedef struct {
    logic [8:0] approx;
    logic [8:0] exact;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] s;
  logic       cout;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsb_two_approx_rc_adder #(.WIDTH(8), .APPROX_BITS(2)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout)
  );

  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic       c;
    logic       cn;
    logic [7:0] r;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      cn = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
      r[i] = (i < 2) ? ~cn : (x[i] ^ y[i] ^ c);
      c = cn;
    end
    return {c, r};
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic ci);
    exp_t e;
    @(negedge clk);
    a = x; b = y; cin = ci;
    e.approx = ref_add(x, y, ci);
    e.exact  = 9'(x) + 9'(y) + 9'(ci);
    q.push_back(e);
  endtask

  task automatic capture(input string tag, input logic full);
    exp_t e;
    logic [8:0] got;
    int diff;
    @(posedge clk);
    #1;
    got = {cout, s};
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: got %h expected scoreboard entry (queue empty)", tag, got);
      return;
    end
    e = q.pop_front();
    chk(tag, got, e.approx);
    if (full) begin
      chk({tag, "_upper"}, {got[8:2], 2'b00}, {e.exact[8:2], 2'b00});
      diff = int'(got) - int'(e.exact);
      if (diff < 0) diff = -diff;
      chk({tag, "_bound"}, 9'(diff <= 3), 9'd1);
    end
  endtask

  initial begin
    rst = 1'b1; a = 8'h00; b = 8'h00; cin = 1'b0;
    #1;
    chk("reset_init", {cout, s}, 9'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero operands expose the error in both approximate bits.
    drive(8'd0, 8'd0, 1'b0);
    capture("zero", 1'b0);

    // Asynchronous reset between edges clears a live result.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    rst = 1'b1;
    #1;
    chk("reset_async", {cout, s}, 9'h000);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {cout, s}, 9'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    chk("reset_expect", ref_add(8'hFF, 8'hFF, 1'b1), 9'h1FC);
    q.push_back('{approx: 9'h1FC, exact: 9'h1FF});
    capture("reset_release", 1'b1);

    drive(8'hAA, 8'h55, 1'b0);
    capture("aa_55", 1'b0);
    chk("aa_55_const", {cout, s}, 9'd255);
    drive(8'hFF, 8'h01, 1'b0);
    capture("ff_01", 1'b0);
    chk("ff_01_const", {cout, s}, 9'd256);
    drive(8'd200, 8'd100, 1'b0);
    capture("200_100", 1'b0);
    chk("200_100_const", {cout, s}, 9'd303);
    drive(8'd3, 8'd3, 1'b1);
    capture("3_3_1", 1'b0);
    chk("3_3_1_const", {cout, s}, 9'h004);

    // Back-to-back: new operands every cycle, outputs one cycle behind.
    drive(8'd0, 8'd0, 1'b0);
    capture("b2b_0", 1'b0);
    chk("b2b_0_const", {cout, s}, 9'd3);
    drive(8'd255, 8'd1, 1'b0);
    capture("b2b_1", 1'b0);
    chk("b2b_1_const", {cout, s}, 9'd256);
    drive(8'd170, 8'd85, 1'b0);
    capture("b2b_2", 1'b0);
    chk("b2b_2_const", {cout, s}, 9'd255);

    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        drive(8'(x), 8'(y), 1'b0);
        capture("sweep", 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
